// File: rtl/jt5911_ctrl.sv
// jt5911_ctrl: host command sequencer for an ER5911/93C46-style 3-wire EEPROM with RDY polling.
// cmd_ack->done latency without polling is exactly (4 + 2*sclk_pulses)*CLKDIV clk (constant 0).
module jt5911_ctrl #(
    parameter int PROG   = 0,
    parameter int CLKDIV = 4,
    parameter int TMO    = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_req,
    input  logic [2:0]  cmd_op,
    input  logic [6:0]  cmd_addr,
    input  logic [15:0] cmd_din,
    output logic        cmd_ack,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] rd_data,
    output logic        scs,
    output logic        sclk,
    output logic        sdi,
    input  logic        sdo,
    input  logic        rdy
);
    localparam int AW  = PROG ? 6 : 7;
    localparam int DW  = PROG ? 16 : 8;
    localparam int CW  = PROG ? 12 : 11;
    localparam int FW  = 2 + CW + DW;
    localparam int DVW = $clog2(CLKDIV);
    localparam int TW  = $clog2(TMO + 1);
    localparam int NW  = $clog2(FW + 1);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, POLL, GAP, DONE} state_t;

    state_t         state, nxt;
    logic [DVW-1:0] div;
    logic [1:0]     hc;
    logic           ph;
    logic [NW-1:0]  cnt, last;
    logic [FW-1:0]  sh;
    logic [DW-1:0]  rsh;
    logic [2:0]     op;
    logic [TW-1:0]  tcnt;
    logic [3:0]     op4;
    logic           tick, bit_end, tmo_hit, is_rd, is_wr, is_er, unused_bits;

    assign tick        = div == DVW'(CLKDIV - 1);
    assign is_rd       = op == 3'd0;
    assign is_wr       = op == 3'd1;
    assign is_er       = op == 3'd4;
    assign last        = (is_rd || is_wr) ? NW'(FW - 1) : NW'(CW + 1);
    assign bit_end     = state == XFER && tick && ph;
    assign tmo_hit     = tcnt == TW'(TMO - 1);
    assign op4         = cmd_op == 3'd0 ? 4'b1000 : cmd_op == 3'd1 ? 4'b0100 :
                         cmd_op == 3'd2 ? 4'b0011 : cmd_op == 3'd4 ? 4'b0010 : 4'b0000;
    assign unused_bits = ^{cmd_addr, cmd_din};

    assign busy = state != IDLE && state != DONE;
    assign done = state == DONE;
    assign scs  = state == SETUP || state == XFER || state == POLL;
    assign sclk = state == XFER && ph;
    assign sdi  = state == XFER && sh[FW-1];

    // One XFER state walks the whole frame: pre bit, start bit, command, then write/read data.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = cmd_req ? (cmd_op > 3'd4 ? DONE : SETUP) : IDLE;
            SETUP:   nxt = (tick && hc[0]) ? XFER : SETUP;
            XFER:    nxt = (bit_end && cnt == last) ? ((is_wr || is_er) ? POLL : GAP) : XFER;
            POLL:    nxt = (hc[1] && (rdy || tmo_hit)) ? GAP : POLL;
            GAP:     nxt = (tick && hc[0]) ? DONE : GAP;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            div     <= '0;
            hc      <= '0;
            ph      <= 1'b0;
            cnt     <= '0;
            sh      <= '0;
            rsh     <= '0;
            op      <= '0;
            tcnt    <= '0;
            err     <= 1'b0;
            cmd_ack <= 1'b0;
            rd_data <= '0;
        end else begin
            state   <= nxt;
            cmd_ack <= state == IDLE && cmd_req;
            div     <= (state == IDLE || (state == POLL && nxt == GAP) || tick) ? '0 : div + 1'b1;
            hc      <= nxt != state ? '0 : hc + {1'b0, tick && !hc[1]};
            ph      <= state == XFER && (ph ^ tick);
            cnt     <= state == XFER ? cnt + NW'(bit_end) : '0;
            tcnt    <= (state == POLL && hc[1]) ? tcnt + 1'b1 : '0;
            if (state == IDLE && cmd_req) begin
                op  <= cmd_op;
                err <= cmd_op > 3'd4;
                sh  <= {2'b01, op4, (CW - 4)'(cmd_addr[AW-1:0]), cmd_din[DW-1:0]};
            end
            if (state == POLL && nxt == GAP && !rdy) err <= 1'b1;
            if (bit_end) begin
                sh  <= sh << 1;
                rsh <= {rsh[DW-2:0], sdo};
            end
            if (bit_end && cnt == last && is_rd) rd_data <= 16'({rsh[DW-2:0], sdo});
        end
    end
endmodule

// File: tb/tb_jt5911_ctrl.sv
// tb_jt5911_ctrl: directed plus randomized checks of jt5911_ctrl against a behavioural EEPROM and reference memory.
module tb_jt5911_ctrl;
    localparam int CLKDIV = 4;
    localparam int TMO    = 4096;
    localparam int CW     = 11;
    localparam logic [2:0] RD = 3'd0, WR = 3'd1, EWEN = 3'd2, EWDS = 3'd3, ERAL = 3'd4;

    logic        clk = 1'b0, rst_n = 1'b0, cmd_req = 1'b0, sdo = 1'b0, rdy = 1'b1;
    logic [2:0]  cmd_op = '0;
    logic [6:0]  cmd_addr = '0;
    logic [15:0] cmd_din = '0;
    logic        cmd_ack, busy, done, err, scs, sclk, sdi;
    logic [15:0] rd_data;

    int          n_cmp = 0, n_bad = 0;
    logic [7:0]  ref_mem [128];
    bit          ref_en = 0;
    logic [15:0] exp_rd = '0;
    int          last_bb = 0, last_rl = 0;
    bit          last_ss = 0;

    logic [7:0]  dmem [128];
    bit          den = 0, force_low = 0, prev_sclk = 0, prev_scs = 0, started = 0, had_frame = 0;
    int          dbusy = 0, nb = 0, edges = 0, last_edges = 0, low_cnt = 0;
    logic [10:0] dcmd = '0;
    logic [7:0]  dsh = '0;

    always #5 clk = ~clk;

    jt5911_ctrl #(.PROG(0), .CLKDIV(CLKDIV), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_req(cmd_req), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_din(cmd_din), .cmd_ack(cmd_ack), .busy(busy), .done(done), .err(err),
        .rd_data(rd_data), .scs(scs), .sclk(sclk), .sdi(sdi), .sdo(sdo), .rdy(rdy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // EEPROM device: decodes frames on sclk rising edges, shifts read data out after each rising edge.
    always @(negedge clk) begin
        if (dbusy > 0) dbusy--;
        if (scs && !prev_scs) begin
            if (had_frame) check("cs_gap", 32'(low_cnt >= 2 * CLKDIV), 1);
            started = 0;
            nb = 0;
            edges = 0;
        end
        if (!scs && prev_scs) begin
            last_edges = edges;
            had_frame = 1;
        end
        low_cnt = scs ? 0 : low_cnt + 1;
        if (scs && sclk && !prev_sclk) begin
            edges++;
            if (!started) started = sdi;
            else if (nb < CW) begin
                dcmd = {dcmd[9:0], sdi};
                nb++;
                if (nb == CW) begin
                    if (dcmd[10:7] == 4'b1000) dsh = dmem[dcmd[6:0]];
                    if (dcmd[10:7] == 4'b0011) den = 1;
                    if (dcmd[10:7] == 4'b0000) den = 0;
                    if (dcmd[10:7] == 4'b0010 && den) begin
                        foreach (dmem[i]) dmem[i] = 8'hFF;
                        dbusy = 30;
                    end
                end
            end else begin
                nb++;
                if (dcmd[10:7] == 4'b1000) begin
                    sdo = dsh[7];
                    dsh = dsh << 1;
                end
                if (dcmd[10:7] == 4'b0100) begin
                    dsh = {dsh[6:0], sdi};
                    if (nb == CW + 8 && den) begin
                        dmem[dcmd[6:0]] = dsh;
                        dbusy = 30;
                    end
                end
            end
        end
        rdy = !(dbusy > 0 || force_low);
        prev_sclk = sclk;
        prev_scs = scs;
    end

    task automatic run(input logic [2:0] op, input logic [6:0] a, input logic [15:0] d,
                       output int lat, output logic e, output logic [15:0] rdv);
        int w = 0;
        @(negedge clk);
        cmd_op = op;
        cmd_addr = a;
        cmd_din = d;
        cmd_req = 1;
        @(negedge clk);
        while (!cmd_ack && w < 20) begin
            @(negedge clk);
            w++;
        end
        cmd_req = 0;
        check($sformatf("ack op%0d", op), cmd_ack, 1);
        lat = 0;
        last_bb = 0;
        last_rl = 0;
        last_ss = scs;
        while (!done && lat < 20000) begin
            if (!rdy && !busy) last_bb++;
            if (!rdy) last_rl++;
            last_ss |= scs;
            @(negedge clk);
            lat++;
        end
        check($sformatf("done op%0d", op), done, 1);
        check($sformatf("busy_at_done op%0d", op), busy, 0);
        e = err;
        rdv = rd_data;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [6:0] a, input logic [15:0] d,
                         input logic exp_err, output int lat);
        logic e;
        logic [15:0] rdv;
        run(op, a, d, lat, e, rdv);
        check($sformatf("err op%0d a%02h", op, a), e, exp_err);
        if (op == RD) exp_rd = {8'h00, ref_mem[a]};
        check($sformatf("rd op%0d a%02h", op, a), rdv, exp_rd);
        if (op == WR && ref_en) ref_mem[a] = d[7:0];
        if (op == EWEN) ref_en = 1;
        if (op == EWDS) ref_en = 0;
        if (op == ERAL && ref_en) foreach (ref_mem[i]) ref_mem[i] = 8'hFF;
    endtask

    initial begin
        int lat, w, hi, r;
        logic [2:0] rop;
        logic [6:0] ra;
        logic [15:0] rdin;
        foreach (dmem[i]) begin
            dmem[i] = 8'hFF;
            ref_mem[i] = 8'hFF;
        end
        repeat (3) @(negedge clk);
        check("rst_scs", scs, 0);
        check("rst_sclk", sclk, 0);
        check("rst_sdi", sdi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack", cmd_ack, 0);
        check("rst_err", err, 0);
        check("rst_rd", rd_data, 0);
        rst_n = 1;
        hi = 0;
        repeat (20) begin
            @(negedge clk);
            hi += int'(sclk) + int'(scs) + int'(busy);
        end
        check("idle_quiet", hi, 0);

        do_op(EWEN, 7'h00, 16'h0000, 0, lat);
        do_op(WR, 7'h12, 16'h00A5, 0, lat);
        do_op(RD, 7'h12, 16'h0000, 0, lat);
        check("rd_a5", rd_data, 16'h00A5);
        check("rd_lat", lat, (4 + 2 * 21) * CLKDIV);
        check("rd_edges", last_edges, 21);

        do_op(EWDS, 7'h00, 16'h0000, 0, lat);
        do_op(WR, 7'h12, 16'h003C, 0, lat);
        do_op(RD, 7'h12, 16'h0000, 0, lat);
        check("rd_protected", rd_data, 16'h00A5);

        do_op(EWEN, 7'h00, 16'h0000, 0, lat);
        do_op(ERAL, 7'h00, 16'h0000, 0, lat);
        check("eral_rdy_low_seen", 32'(last_rl > 0), 1);
        check("eral_busy_while_rdy_low", last_bb, 0);
        do_op(RD, 7'h7F, 16'h0000, 0, lat);
        check("eral_7f", rd_data, 16'h00FF);
        do_op(RD, 7'h00, 16'h0000, 0, lat);
        check("eral_00", rd_data, 16'h00FF);

        force_low = 1;
        do_op(WR, 7'h05, 16'h0011, 1, lat);
        check("tmo_lat", lat, 48 * CLKDIV + TMO);
        check("tmo_scs", scs, 0);
        force_low = 0;

        do_op(3'd6, 7'h12, 16'h1234, 1, lat);
        check("ill_lat", lat, 0);
        check("ill_scs", last_ss, 0);
        repeat (3) @(negedge clk);
        check("err_hold", err, 1);

        @(negedge clk);
        cmd_op = RD;
        cmd_addr = 7'h12;
        cmd_req = 1;
        @(negedge clk);
        cmd_req = 0;
        w = 0;
        while (!(started && nb >= 3 && sclk) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("cmd_reached", 32'(w < 2000), 1);
        #2 rst_n = 0;
        #1;
        check("arst_scs", scs, 0);
        check("arst_sclk", sclk, 0);
        check("arst_busy", busy, 0);
        repeat (10) @(negedge clk);
        rst_n = 1;
        exp_rd = '0;
        check("arst_rd", rd_data, 0);
        do_op(RD, 7'h12, 16'h0000, 0, lat);
        check("post_rst_rd", rd_data, 16'h00FF);

        for (int k = 0; k < 24; k++) begin
            r = $urandom_range(0, 9);
            rop = r < 3 ? RD : r < 6 ? WR : r == 6 ? EWEN : r == 7 ? EWDS : r == 8 ? ERAL :
                  3'($urandom_range(5, 7));
            ra = 7'($urandom_range(0, 7));
            rdin = 16'($urandom);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            do_op(rop, ra, rdin, rop > 3'd4, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
